sv_bus_mux_demux_arb: RTL and testbench

- Round-robin arbiter that shares the single bus input of the bus-to-stream multiplexer between N bus masters.
- Sits in front of the mux bus port (vld/adr/dat/rdy).
- Grants one master at a time and holds the grant for a burst of up to BURST transfers.
- Routes the granted master's request to the shared bus and returns rdy only to that master.

---
 rtl/sv_bus_mux_demux_arb_if.sv | 31 +++
 rtl/sv_bus_mux_demux_arb.sv | 128 ++++++++++++
 tb/tb_sv_bus_mux_demux_arb.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sv_bus_mux_demux_arb_if.sv
// Shared request/bus bundle between N bus masters, the round-robin arbiter and
// the downstream bus-to-stream mux.
//   req_vld/req_adr/req_dat : per-master request, master i in slice i
//   req_rdy                 : per-master ready, at most one bit set
//   bus_vld/bus_adr/bus_dat : shared bus towards the mux
//   bus_rdy                 : shared bus ready from the mux
// Modport slave is the arbiter's view; modport master is the requester/mux side.
interface sv_bus_mux_demux_arb_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [N-1:0]    req_vld;
    logic [N*AW-1:0] req_adr;
    logic [N*DW-1:0] req_dat;
    logic [N-1:0]    req_rdy;
    logic            bus_vld;
    logic [AW-1:0]   bus_adr;
    logic [DW-1:0]   bus_dat;
    logic            bus_rdy;

    modport slave (
        input  req_vld, req_adr, req_dat, bus_rdy,
        output req_rdy, bus_vld, bus_adr, bus_dat
    );

    modport master (
        output req_vld, req_adr, req_dat, bus_rdy,
        input  req_rdy, bus_vld, bus_adr, bus_dat
    );
endinterface

// File: rtl/sv_bus_mux_demux_arb.sv
// Round-robin arbiter sharing one bus port between N masters. A grant is held
// for up to BURST transfers, then released for at least one IDLE cycle.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   bus     : request/bus bundle (slave modport)
//   gnt_idx : current/last granted master, qualify with busy
//   busy    : high while a grant is held
module sv_bus_mux_demux_arb #(
    parameter int unsigned N     = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sv_bus_mux_demux_arb_if.slave bus,
    output logic [$clog2(N)-1:0]  gnt_idx,
    output logic                  busy
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;
    logic [BW-1:0] beat_q, beat_d;

    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    int unsigned   scan;
    logic          sel_vld;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_dat;

    // Round-robin pick: first requester after last_q, wrapping mod N
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            scan = (32'(last_q) + k) % N;
            if (!pick_vld && bus.req_vld[IW'(scan)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(scan);
            end
        end
    end

    // Select the granted master's request
    always_comb begin
        sel_vld = 1'b0;
        sel_adr = '0;
        sel_dat = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_q == IW'(i)) begin
                sel_vld = bus.req_vld[i];
                sel_adr = bus.req_adr[i*AW +: AW];
                sel_dat = bus.req_dat[i*DW +: DW];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Next state and bus routing; bus_rdy only feeds req_rdy, never bus_vld
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        beat_d      = beat_q;
        bus.bus_vld = 1'b0;
        bus.bus_adr = '0;
        bus.bus_dat = '0;
        bus.req_rdy = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                    beat_d  = '0;
                end
            end
            BUSY: begin
                bus.bus_vld        = sel_vld;
                bus.bus_adr        = sel_adr;
                bus.bus_dat        = sel_dat;
                bus.req_rdy[gnt_q] = bus.bus_rdy;
                if (!sel_vld) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (bus.bus_rdy) begin
                    if (beat_q == BEAT_MAX) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_idx = gnt_q;
    assign busy    = (state_q == BUSY);
endmodule

// File: tb/tb_sv_bus_mux_demux_arb.sv
module tb_sv_bus_mux_demux_arb;
    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BURST = 4;
    localparam int IW    = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [IW-1:0] gnt_idx;
    logic          busy;

    logic [N-1:0]  vld;
    logic [AW-1:0] adr [N];
    logic [DW-1:0] dat [N];
    logic          rdy;

    int tests = 0;
    int fails = 0;

    // Reference model: current owner (-1 = none), beats done, rr pointer, last grant
    int m_own, m_beats, m_ptr, m_gnt;

    sv_bus_mux_demux_arb_if #(.N(N), .AW(AW), .DW(DW)) bus_if ();

    sv_bus_mux_demux_arb #(.N(N), .AW(AW), .DW(DW), .BURST(BURST)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .gnt_idx (gnt_idx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    assign bus_if.req_vld = vld;
    assign bus_if.bus_rdy = rdy;
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign bus_if.req_adr[g*AW +: AW] = adr[g];
        assign bus_if.req_dat[g*DW +: DW] = dat[g];
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vld = '0;
        rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            adr[i] = '0;
            dat[i] = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        vld = '1;
        rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            adr[i] = AW'(32'h4000 + i);
            dat[i] = DW'(32'h5000 + i);
        end
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (bus_if.bus_vld !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle: bus_vld=%0b busy=%0b expected 0/0", bus_if.bus_vld, busy);
            end
            tests++;
            if (bus_if.req_rdy !== '0 || gnt_idx !== '0 || bus_if.bus_adr !== '0) begin
                fails++;
                $display("FAIL reset_regs: req_rdy=%b gnt=%0d bus_adr=%h expected 0/0/0",
                         bus_if.req_rdy, gnt_idx, bus_if.bus_adr);
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_idle: busy=%0b expected 0", busy);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || gnt_idx !== IW'(0) || bus_if.req_rdy !== 4'b0001 || bus_if.bus_adr !== adr[0]) begin
            fails++;
            $display("FAIL reset_first_grant: busy=%0b gnt=%0d req_rdy=%b adr=%h expected 1/0/0001/%h",
                     busy, gnt_idx, bus_if.req_rdy, bus_if.bus_adr, adr[0]);
        end
    endtask

    task automatic test_single();
        do_reset();
        vld[2] = 1'b1;
        adr[2] = 32'h0000_1000;
        dat[2] = 32'hA5A5_A5A5;
        rdy    = 1'b1;
        @(negedge clk);
        tests++;
        if (bus_if.bus_vld !== 1'b0) begin
            fails++;
            $display("FAIL single_latency: bus_vld=%0b expected 0", bus_if.bus_vld);
        end
        next_cyc();
        @(negedge clk);
        tests++;
        if (bus_if.bus_vld !== 1'b1 || bus_if.bus_adr !== 32'h0000_1000 || bus_if.bus_dat !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL single_route: vld=%0b adr=%h dat=%h expected 1/00001000/a5a5a5a5",
                     bus_if.bus_vld, bus_if.bus_adr, bus_if.bus_dat);
        end
        tests++;
        if (bus_if.req_rdy !== 4'b0100 || gnt_idx !== IW'(2) || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: req_rdy=%b gnt=%0d busy=%0b expected 0100/2/1",
                     bus_if.req_rdy, gnt_idx, busy);
        end
        next_cyc();
        clear_inputs();
    endtask

    task automatic test_burst();
        logic [8:0] obs;
        int beat;
        logic x;
        do_reset();
        obs    = '0;
        beat   = 0;
        vld[1] = 1'b1;
        adr[1] = 32'h100;
        dat[1] = 32'hD0;
        rdy    = 1'b1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(negedge clk);
            x = bus_if.bus_vld && bus_if.req_rdy[1];
            obs[cyc] = x;
            if (x) begin
                tests++;
                if (bus_if.bus_adr !== AW'(32'h100 + beat) || gnt_idx !== IW'(1)) begin
                    fails++;
                    $display("FAIL burst_beat%0d: adr=%h gnt=%0d expected %h/1",
                             beat, bus_if.bus_adr, gnt_idx, 32'h100 + beat);
                end
            end
            next_cyc();
            if (x) begin
                beat++;
                if (beat == 6) vld[1] = 1'b0;
                else begin
                    adr[1] = AW'(32'h100 + beat);
                    dat[1] = DW'(32'hD0 + beat);
                end
            end
        end
        tests++;
        if (obs !== 9'b011011110) begin
            fails++;
            $display("FAIL burst_pattern: transfers=%b expected 011011110", obs);
        end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        int g[5];
        int st[5];
        int exp_g[5];
        int ng;
        logic prev_busy;
        exp_g = '{0, 1, 3, 0, 1};
        do_reset();
        vld = 4'b1011;
        rdy = 1'b1;
        for (int i = 0; i < N; i++) adr[i] = AW'(32'h7000 + i);
        ng = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                g[ng]  = int'(gnt_idx);
                st[ng] = c;
                ng++;
            end
            prev_busy = busy;
            next_cyc();
        end
        tests++;
        if (ng != 5) begin
            fails++;
            $display("FAIL rr_timeout: grants=%0d expected 5", ng);
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests++;
                if (g[k] != exp_g[k]) begin
                    fails++;
                    $display("FAIL rr_grant%0d: gnt=%0d expected %0d", k, g[k], exp_g[k]);
                end
                if (k > 0) begin
                    tests++;
                    if (st[k] - st[k-1] != BURST + 1) begin
                        fails++;
                        $display("FAIL rr_gap%0d: period=%0d expected %0d", k, st[k] - st[k-1], BURST + 1);
                    end
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] held_adr;
        logic [DW-1:0] held_dat;
        int cnt;
        logic done;
        do_reset();
        vld    = 4'b0101;
        adr[0] = 32'h2000; dat[0] = 32'h1111_0000;
        adr[2] = 32'h3000; dat[2] = 32'h2222_0000;
        rdy    = 1'b1;
        next_cyc();
        next_cyc();
        adr[0] = 32'h2001; dat[0] = 32'h1111_0001;
        next_cyc();
        adr[0] = 32'h2002; dat[0] = 32'h1111_0002;
        rdy    = 1'b0;
        held_adr = adr[0];
        held_dat = dat[0];
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            tests++;
            if (bus_if.bus_vld !== 1'b1 || bus_if.bus_adr !== held_adr || bus_if.bus_dat !== held_dat) begin
                fails++;
                $display("FAIL bp_hold%0d: vld=%0b adr=%h dat=%h expected 1/%h/%h",
                         s, bus_if.bus_vld, bus_if.bus_adr, bus_if.bus_dat, held_adr, held_dat);
            end
            tests++;
            if (bus_if.req_rdy !== '0 || busy !== 1'b1 || gnt_idx !== IW'(0)) begin
                fails++;
                $display("FAIL bp_grant%0d: req_rdy=%b busy=%0b gnt=%0d expected 0000/1/0",
                         s, bus_if.req_rdy, busy, gnt_idx);
            end
            next_cyc();
        end
        rdy  = 1'b1;
        cnt  = 0;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
            else begin
                if (bus_if.bus_vld && rdy) begin
                    cnt++;
                    tests++;
                    if (bus_if.req_rdy !== 4'b0001) begin
                        fails++;
                        $display("FAIL bp_rdy_route: req_rdy=%b expected 0001", bus_if.req_rdy);
                    end
                end
                next_cyc();
                adr[0] = adr[0] + 1;
            end
        end
        tests++;
        if (cnt != 2 || !done) begin
            fails++;
            $display("FAIL bp_remaining_beats: beats=%0d released=%0b expected 2/1", cnt, done);
        end
        next_cyc();
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || gnt_idx !== IW'(2)) begin
            fails++;
            $display("FAIL bp_next_grant: busy=%0b gnt=%0d expected 1/2", busy, gnt_idx);
        end
        next_cyc();
        clear_inputs();
    endtask

    task automatic test_early_release_reset();
        do_reset();
        vld    = 4'b1010;
        adr[1] = 32'h11; adr[3] = 32'h33;
        rdy    = 1'b1;
        next_cyc();
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || gnt_idx !== IW'(1) || bus_if.bus_vld !== 1'b1) begin
            fails++;
            $display("FAIL er_grant1: busy=%0b gnt=%0d vld=%0b expected 1/1/1", busy, gnt_idx, bus_if.bus_vld);
        end
        next_cyc();
        next_cyc();
        vld[1] = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || bus_if.bus_vld !== 1'b0) begin
            fails++;
            $display("FAIL er_release: busy=%0b vld=%0b expected 1/0", busy, bus_if.bus_vld);
        end
        next_cyc();
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL er_idle: busy=%0b expected 0", busy);
        end
        next_cyc();
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || gnt_idx !== IW'(3) || bus_if.bus_adr !== 32'h33) begin
            fails++;
            $display("FAIL er_regrant: busy=%0b gnt=%0d adr=%h expected 1/3/00000033",
                     busy, gnt_idx, bus_if.bus_adr);
        end
        next_cyc();
        next_cyc();
        @(negedge clk);
        tests++;
        if (bus_if.bus_vld !== 1'b1) begin
            fails++;
            $display("FAIL er_beat3: vld=%0b expected 1", bus_if.bus_vld);
        end
        #2 rst = 1'b0;
        vld[0] = 1'b1;
        #1;
        tests++;
        if (bus_if.bus_vld !== 1'b0 || busy !== 1'b0 || bus_if.req_rdy !== '0) begin
            fails++;
            $display("FAIL er_async_reset: vld=%0b busy=%0b req_rdy=%b expected 0/0/0000",
                     bus_if.bus_vld, busy, bus_if.req_rdy);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL er_post_reset_idle: busy=%0b expected 0", busy);
        end
        next_cyc();
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || gnt_idx !== IW'(0)) begin
            fails++;
            $display("FAIL er_post_reset_grant: busy=%0b gnt=%0d expected 1/0", busy, gnt_idx);
        end
        next_cyc();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [N-1:0]  xfer_prev;
        logic          e_vld;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [N-1:0]  e_rdy;
        logic          e_busy;
        logic          found;
        int            idx;
        do_reset();
        m_own = -1; m_beats = 0; m_ptr = N - 1; m_gnt = 0;
        xfer_prev = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i]) begin
                    if ($urandom_range(99) < 40) begin
                        vld[i] = 1'b1;
                        adr[i] = $urandom;
                        dat[i] = $urandom;
                    end
                end else if (xfer_prev[i]) begin
                    if ($urandom_range(99) < 60) begin
                        adr[i] = $urandom;
                        dat[i] = $urandom;
                    end else vld[i] = 1'b0;
                end else if ($urandom_range(99) < 3) begin
                    vld[i] = 1'b0;
                end
            end
            rdy = ($urandom_range(99) < 70);

            if (m_own < 0) begin
                e_vld = 1'b0; e_adr = '0; e_dat = '0; e_rdy = '0; e_busy = 1'b0;
            end else begin
                e_vld  = vld[m_own];
                e_adr  = adr[m_own];
                e_dat  = dat[m_own];
                e_rdy  = N'(rdy) << m_own;
                e_busy = 1'b1;
            end

            @(negedge clk);
            tests++;
            if (bus_if.bus_vld !== e_vld || busy !== e_busy) begin
                fails++;
                $display("FAIL rnd_vld c%0d: vld=%0b busy=%0b expected %0b/%0b",
                         c, bus_if.bus_vld, busy, e_vld, e_busy);
            end
            tests++;
            if (bus_if.bus_adr !== e_adr || bus_if.bus_dat !== e_dat) begin
                fails++;
                $display("FAIL rnd_data c%0d: adr=%h dat=%h expected %h/%h",
                         c, bus_if.bus_adr, bus_if.bus_dat, e_adr, e_dat);
            end
            tests++;
            if (bus_if.req_rdy !== e_rdy || gnt_idx !== IW'(m_gnt)) begin
                fails++;
                $display("FAIL rnd_grant c%0d: req_rdy=%b gnt=%0d expected %b/%0d",
                         c, bus_if.req_rdy, gnt_idx, e_rdy, m_gnt);
            end

            @(posedge clk);
            for (int i = 0; i < N; i++) xfer_prev[i] = (m_own == i) && vld[i] && rdy;
            if (m_own < 0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && vld[idx]) begin
                        found = 1'b1;
                        m_own = idx; m_ptr = idx; m_gnt = idx; m_beats = 0;
                    end
                end
            end else if (!vld[m_own]) begin
                m_own = -1;
            end else if (rdy) begin
                m_beats++;
                if (m_beats == BURST) m_own = -1;
            end
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_burst();
        test_round_robin();
        test_backpressure();
        test_early_release_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
